// File: rtl/midi_voice_alloc.sv
// MIDI byte-stream parser and voice allocator feeding the 64-oscillator wave generator.
// Parses note on/off and program change, picks an oscillator slot by linear scan,
// converts note numbers to integer-Hz targets and issues one oscillator update per message.
module midi_voice_alloc #(
    parameter int NUM_OSC = 64,
    parameter int OMNI    = 1,
    parameter int CHANNEL = 0
) (
    input  logic        i_clk48,
    input  logic        i_rst48,
    input  logic [7:0]  i_midi_byte,
    input  logic        i_midi_valid,
    output logic        o_midi_ready,
    output logic [5:0]  o_osc_sel,
    output logic [7:0]  o_wav_sel,
    output logic        o_ws_valid,
    output logic [23:0] o_t_freq,
    output logic        o_tf_valid,
    output logic [6:0]  o_active_cnt
);

    localparam int unsigned IW = 6;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OSC - 1);

    typedef enum logic [2:0] {IDLE, SCAN, SETUP, WAV, FREQ} state_t;
    typedef enum logic [1:0] {K_OFF, K_ON, K_PROG} kind_t;

    state_t          state;
    logic            rs_valid;
    kind_t           rs_kind;
    logic            data_cnt;
    logic [6:0]      d0;
    logic [6:0]      msg_note;
    logic            msg_on;
    logic [1:0]      prog_wav;
    logic [NUM_OSC-1:0] voice_active;
    logic [6:0]      voice_note [NUM_OSC];
    logic [IW-1:0]   scan_idx;
    logic            hit_found;
    logic [IW-1:0]   hit_idx;
    logic            free_found;
    logic [IW-1:0]   free_idx;
    logic [IW-1:0]   steal_ptr;
    logic            alloc_new;

    logic            accept_c;
    logic            chan_ok_c;
    logic            cur_hit_c;
    logic            cur_free_c;
    logic            hit_any_c;
    logic [IW-1:0]   hit_sel_c;
    logic            free_any_c;
    logic [IW-1:0]   free_sel_c;
    logic [IW-1:0]   alloc_sel_c;
    logic [3:0]      oct_c;
    logic [3:0]      semi_c;
    logic [15:0]     base_c;
    logic [15:0]     shifted_c;
    logic [23:0]     freq_c;

    // Byte handshake, channel filter and per-cycle scan comparison
    always_comb begin
        accept_c    = i_midi_valid && o_midi_ready;
        chan_ok_c   = (OMNI != 0) || (i_midi_byte[3:0] == 4'(CHANNEL));
        cur_hit_c   = voice_active[scan_idx] && (voice_note[scan_idx] == msg_note);
        cur_free_c  = !voice_active[scan_idx];
        hit_any_c   = hit_found || cur_hit_c;
        hit_sel_c   = hit_found ? hit_idx : scan_idx;
        free_any_c  = free_found || cur_free_c;
        free_sel_c  = free_found ? free_idx : scan_idx;
        alloc_sel_c = hit_any_c ? hit_sel_c : (free_any_c ? free_sel_c : steal_ptr);
    end

    // Note number to integer Hz: top-octave base value shifted down by octave
    always_comb begin
        oct_c  = 4'(msg_note / 7'd12);
        semi_c = 4'(msg_note % 7'd12);
        base_c = 16'd0;
        case (semi_c)
            4'd0:  base_c = 16'd8372;
            4'd1:  base_c = 16'd8870;
            4'd2:  base_c = 16'd9397;
            4'd3:  base_c = 16'd9956;
            4'd4:  base_c = 16'd10548;
            4'd5:  base_c = 16'd11175;
            4'd6:  base_c = 16'd11840;
            4'd7:  base_c = 16'd12544;
            4'd8:  base_c = 16'd13290;
            4'd9:  base_c = 16'd14080;
            4'd10: base_c = 16'd14917;
            4'd11: base_c = 16'd15804;
            default: base_c = 16'd0;
        endcase
        shifted_c = base_c >> (4'd10 - oct_c);
        freq_c    = {8'd0, shifted_c};
    end

    // Parser, voice table and output sequencing FSM
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            state        <= IDLE;
            o_midi_ready <= 1'b1;
            o_osc_sel    <= '0;
            o_wav_sel    <= '0;
            o_ws_valid   <= 1'b0;
            o_t_freq     <= '0;
            o_tf_valid   <= 1'b0;
            o_active_cnt <= '0;
            rs_valid     <= 1'b0;
            rs_kind      <= K_OFF;
            data_cnt     <= 1'b0;
            d0           <= '0;
            msg_note     <= '0;
            msg_on       <= 1'b0;
            prog_wav     <= '0;
            voice_active <= '0;
            scan_idx     <= '0;
            hit_found    <= 1'b0;
            hit_idx      <= '0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            steal_ptr    <= '0;
            alloc_new    <= 1'b0;
        end else begin
            o_ws_valid <= 1'b0;
            o_tf_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c && i_midi_byte[7] && (i_midi_byte < 8'hF8)) begin
                        // Status byte: only note off/on and program change arm running status
                        data_cnt <= 1'b0;
                        rs_valid <= 1'b0;
                        if (chan_ok_c) begin
                            case (i_midi_byte[7:4])
                                4'h8: begin rs_valid <= 1'b1; rs_kind <= K_OFF;  end
                                4'h9: begin rs_valid <= 1'b1; rs_kind <= K_ON;   end
                                4'hC: begin rs_valid <= 1'b1; rs_kind <= K_PROG; end
                                default: rs_valid <= 1'b0;
                            endcase
                        end
                    end else if (accept_c && !i_midi_byte[7] && rs_valid) begin
                        if (rs_kind == K_PROG) begin
                            prog_wav <= i_midi_byte[1:0];
                        end else if (!data_cnt) begin
                            d0       <= i_midi_byte[6:0];
                            data_cnt <= 1'b1;
                        end else begin
                            data_cnt     <= 1'b0;
                            msg_note     <= d0;
                            msg_on       <= (rs_kind == K_ON) && (i_midi_byte[6:0] != 7'd0);
                            scan_idx     <= '0;
                            hit_found    <= 1'b0;
                            free_found   <= 1'b0;
                            state        <= SCAN;
                            o_midi_ready <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    scan_idx   <= scan_idx + IW'(1);
                    hit_found  <= hit_any_c;
                    hit_idx    <= hit_sel_c;
                    free_found <= free_any_c;
                    free_idx   <= free_sel_c;
                    if (scan_idx == LAST_IDX) begin
                        if (msg_on) begin
                            state                    <= SETUP;
                            o_osc_sel                <= alloc_sel_c;
                            voice_active[alloc_sel_c] <= 1'b1;
                            voice_note[alloc_sel_c]  <= msg_note;
                            alloc_new                <= !hit_any_c && free_any_c;
                            if (!hit_any_c && !free_any_c) begin
                                steal_ptr <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + IW'(1);
                            end
                        end else if (hit_any_c) begin
                            state                   <= SETUP;
                            o_osc_sel               <= hit_sel_c;
                            voice_active[hit_sel_c] <= 1'b0;
                        end else begin
                            state        <= IDLE;
                            o_midi_ready <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (msg_on) begin
                        state      <= WAV;
                        o_ws_valid <= 1'b1;
                        o_wav_sel  <= {6'd0, prog_wav};
                    end else begin
                        state        <= FREQ;
                        o_tf_valid   <= 1'b1;
                        o_t_freq     <= '0;
                        o_active_cnt <= o_active_cnt - 7'd1;
                    end
                end
                WAV: begin
                    state      <= FREQ;
                    o_tf_valid <= 1'b1;
                    o_t_freq   <= freq_c;
                    if (alloc_new) begin
                        o_active_cnt <= o_active_cnt + 7'd1;
                    end
                end
                FREQ: begin
                    state        <= IDLE;
                    o_midi_ready <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    o_midi_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc: an omni instance and a channel-2-only instance.
module tb_midi_voice_alloc;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [7:0]  midi_byte;
    logic        valid_a, valid_b;

    logic        rdy_a, ws_a, tf_a;
    logic [5:0]  osc_a;
    logic [7:0]  wav_a;
    logic [23:0] freq_a;
    logic [6:0]  cnt_a;

    logic        rdy_b, ws_b, tf_b;
    logic [5:0]  osc_b;
    logic [7:0]  wav_b;
    logic [23:0] freq_b;
    logic [6:0]  cnt_b;

    logic        ch;
    logic        m_ready, m_ws, m_tf;
    logic [5:0]  m_osc;
    logic [7:0]  m_wav;
    logic [23:0] m_freq;
    logic [6:0]  m_cnt;

    int tests = 0;
    int fails = 0;
    int simul = 0;

    always #5 clk = ~clk;

    midi_voice_alloc dut_a (
        .i_clk48(clk), .i_rst48(rst_a), .i_midi_byte(midi_byte), .i_midi_valid(valid_a),
        .o_midi_ready(rdy_a), .o_osc_sel(osc_a), .o_wav_sel(wav_a), .o_ws_valid(ws_a),
        .o_t_freq(freq_a), .o_tf_valid(tf_a), .o_active_cnt(cnt_a)
    );

    midi_voice_alloc #(.NUM_OSC(64), .OMNI(0), .CHANNEL(2)) dut_b (
        .i_clk48(clk), .i_rst48(rst_b), .i_midi_byte(midi_byte), .i_midi_valid(valid_b),
        .o_midi_ready(rdy_b), .o_osc_sel(osc_b), .o_wav_sel(wav_b), .o_ws_valid(ws_b),
        .o_t_freq(freq_b), .o_tf_valid(tf_b), .o_active_cnt(cnt_b)
    );

    assign m_ready = ch ? rdy_b  : rdy_a;
    assign m_ws    = ch ? ws_b   : ws_a;
    assign m_tf    = ch ? tf_b   : tf_a;
    assign m_osc   = ch ? osc_b  : osc_a;
    assign m_wav   = ch ? wav_b  : wav_a;
    assign m_freq  = ch ? freq_b : freq_a;
    assign m_cnt   = ch ? cnt_b  : cnt_a;

    typedef struct {
        string           name;
        logic            c;
        int              nb;
        logic [4:0][7:0] bs;
        int              ws_c;
        int              tf_c;
        int              rdy_c;
        logic [5:0]      osc;
        logic [7:0]      wav;
        logic [23:0]     freq;
        logic [6:0]      cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic c, input int nb,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4,
                       input int ws_c, input int tf_c, input int rdy_c,
                       input logic [5:0] osc, input logic [7:0] wav,
                       input logic [23:0] freq, input logic [6:0] cnt);
        vec_t v;
        v.name = name; v.c = c; v.nb = nb;
        v.bs[0] = b0; v.bs[1] = b1; v.bs[2] = b2; v.bs[3] = b3; v.bs[4] = b4;
        v.ws_c = ws_c; v.tf_c = tf_c; v.rdy_c = rdy_c;
        v.osc = osc; v.wav = wav; v.freq = freq; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // Present one byte on the selected instance once it is ready; returns #1 after acceptance
    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!m_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!m_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready stayed 0, expected 1");
        end
        midi_byte = b;
        if (ch) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Record the first cycle of each pulse and the cycle ready returns, counted from acceptance
    task automatic capture(output int ws_c, output int tf_c, output int rdy_c);
        ws_c = 0; tf_c = 0; rdy_c = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (m_ws && ws_c == 0) ws_c = k;
            if (m_tf && tf_c == 0) tf_c = k;
            if (m_ws && m_tf) simul++;
            if (m_ready) begin
                rdy_c = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int ws_c, tf_c, rdy_c;
        ch = v.c;
        for (int i = 0; i < v.nb; i++) send(v.bs[i]);
        capture(ws_c, tf_c, rdy_c);
        chk({v.name, "_ws_cycle"},  32'(ws_c),  32'(v.ws_c));
        chk({v.name, "_tf_cycle"},  32'(tf_c),  32'(v.tf_c));
        chk({v.name, "_rdy_cycle"}, 32'(rdy_c), 32'(v.rdy_c));
        chk({v.name, "_osc"},  32'(m_osc),  32'(v.osc));
        chk({v.name, "_wav"},  32'(m_wav),  32'(v.wav));
        chk({v.name, "_freq"}, 32'(m_freq), 32'(v.freq));
        chk({v.name, "_cnt"},  32'(m_cnt),  32'(v.cnt));
    endtask

    task automatic reset_dut(input logic c);
        ch = c;
        @(negedge clk);
        if (c) rst_b = 1'b1; else rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic note_on(input string name, input logic [7:0] note, input logic [5:0] osc,
                           input logic [7:0] wav, input logic [23:0] freq, input logic [6:0] cnt);
        vec_t v;
        v.name = name; v.c = 1'b0; v.nb = 3;
        v.bs = '0;
        v.bs[0] = 8'h90; v.bs[1] = note; v.bs[2] = 8'h40;
        v.ws_c = 66; v.tf_c = 67; v.rdy_c = 68;
        v.osc = osc; v.wav = wav; v.freq = freq; v.cnt = cnt;
        run_vec(v);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        midi_byte = 8'h00;
        ch = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        chk("rst_ready", 32'(rdy_a),  32'd1);
        chk("rst_ws",    32'(ws_a),   32'd0);
        chk("rst_tf",    32'(tf_a),   32'd0);
        chk("rst_osc",   32'(osc_a),  32'd0);
        chk("rst_wav",   32'(wav_a),  32'd0);
        chk("rst_freq",  32'(freq_a), 32'd0);
        chk("rst_cnt",   32'(cnt_a),  32'd0);
        chk("rst_b_ready", 32'(rdy_b), 32'd1);

        //   name          ch  nb  bytes                          ws  tf  rdy osc wav freq    cnt
        add("on69",        0,  3, 8'h90,8'h45,8'h64,8'h00,8'h00, 66, 67, 68, 0, 0, 440,   1);
        add("rs60",        0,  2, 8'h3C,8'h40,8'h00,8'h00,8'h00, 66, 67, 68, 1, 0, 261,   2);
        add("off69",       0,  3, 8'h80,8'h45,8'h00,8'h00,8'h00,  0, 66, 67, 0, 0, 0,     1);
        add("prog3",       0,  2, 8'hC0,8'h03,8'h00,8'h00,8'h00,  0,  0,  1, 0, 0, 0,     1);
        add("on72",        0,  3, 8'h90,8'h48,8'h7F,8'h00,8'h00, 66, 67, 68, 0, 3, 523,   2);
        add("retrig72",    0,  3, 8'h90,8'h48,8'h7F,8'h00,8'h00, 66, 67, 68, 0, 3, 523,   2);
        add("rt_inside",   0,  4, 8'h90,8'h3E,8'hF8,8'h50,8'h00, 66, 67, 68, 2, 3, 293,   3);
        add("vel0_off",    0,  3, 8'h90,8'h3E,8'h00,8'h00,8'h00,  0, 66, 67, 2, 3, 0,     2);
        add("ctl_drop",    0,  5, 8'hB0,8'h07,8'h40,8'h3C,8'h40,  0,  0,  1, 2, 3, 0,     2);
        add("off_nomatch", 0,  3, 8'h80,8'h7F,8'h00,8'h00,8'h00,  0,  0, 65, 2, 3, 0,     2);
        add("on127",       0,  3, 8'h90,8'h7F,8'h01,8'h00,8'h00, 66, 67, 68, 2, 3, 12544, 3);
        add("on0",         0,  3, 8'h90,8'h00,8'h01,8'h00,8'h00, 66, 67, 68, 3, 3, 8,     4);
        add("rt_status",   0,  4, 8'hFE,8'h05,8'hF8,8'h01,8'h00, 66, 67, 68, 4, 3, 10,    5);
        add("sysex_clr",   0,  3, 8'hF0,8'h45,8'h40,8'h00,8'h00,  0,  0,  1, 4, 3, 10,    5);
        add("prog1_retrig",0,  5, 8'hC5,8'h01,8'h90,8'h3C,8'h40, 66, 67, 68, 1, 1, 261,   5);
        add("b_ch1_filt",  1,  3, 8'h91,8'h45,8'h40,8'h00,8'h00,  0,  0,  1, 0, 0, 0,     0);
        add("b_ch2_on",    1,  3, 8'h92,8'h45,8'h40,8'h00,8'h00, 66, 67, 68, 0, 0, 440,   1);
        add("b_filt_rs",   1,  3, 8'h91,8'h46,8'h40,8'h00,8'h00,  0,  0,  1, 0, 0, 440,   1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Fill every slot, then exercise steal, retrigger and release with a full table
        reset_dut(1'b0);
        for (int n = 0; n < 64; n++) begin
            logic [23:0] f;
            int o, s;
            logic [15:0] base [12];
            base = '{16'd8372, 16'd8870, 16'd9397, 16'd9956, 16'd10548, 16'd11175,
                     16'd11840, 16'd12544, 16'd13290, 16'd14080, 16'd14917, 16'd15804};
            o = n / 12;
            s = n % 12;
            f = 24'(base[s] >> (10 - o));
            note_on($sformatf("fill%0d", n), 8'(n), 6'(n), 8'd0, f, 7'(n + 1));
        end
        note_on("steal100",   8'd100, 6'd0, 8'd0, 24'd2637, 7'd64);
        note_on("steal101",   8'd101, 6'd1, 8'd0, 24'd2793, 7'd64);
        note_on("retrig100",  8'd100, 6'd0, 8'd0, 24'd2637, 7'd64);
        begin
            vec_t v;
            v.name = "full_off100"; v.c = 1'b0; v.nb = 3; v.bs = '0;
            v.bs[0] = 8'h80; v.bs[1] = 8'd100; v.bs[2] = 8'h00;
            v.ws_c = 0; v.tf_c = 66; v.rdy_c = 67;
            v.osc = 6'd0; v.wav = 8'd0; v.freq = 24'd0; v.cnt = 7'd63;
            run_vec(v);
        end
        note_on("refill102",  8'd102, 6'd0, 8'd0, 24'd2960, 7'd64);
        note_on("steal103",   8'd103, 6'd2, 8'd0, 24'd3136, 7'd64);

        // Reset in the middle of a scan aborts the message
        ch = 1'b1;
        send(8'h92);
        send(8'h46);
        send(8'h40);
        repeat (10) @(negedge clk);
        chk("midscan_busy", 32'(rdy_b), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("midscan_ready", 32'(rdy_b), 32'd1);
        chk("midscan_cnt",   32'(cnt_b), 32'd0);
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ws_b || tf_b) pulses++;
        end
        chk("midscan_no_pulse", 32'(pulses), 32'd0);
        add("b_after_rst", 1, 3, 8'h92,8'h46,8'h40,8'h00,8'h00, 66, 67, 68, 0, 0, 466, 1);
        run_vec(tbl[tbl.size() - 1]);

        chk("no_simul_pulse", 32'(simul), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
